// File: rtl/lsu_mem_ctrl.sv
// Load/store unit for the MIPS data memory: byte/half/word accesses with sub-word RMW and load extension.
// Optional `LSU_RANGE_CHECK_EN flags byte addresses above the 16 KB window as errors.
module lsu_mem_ctrl #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [31:0]       mem_read_data
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCESS = 3'd1,
    S_WRITE  = 3'd2,
    S_RESP   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_write;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [1:0]        r_off;
  logic [31:0]       r_wdata;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [31:0]       r_resp_rdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;

  logic w_accept;
  logic w_req_err;
  logic w_word_store;

  // Pull the addressed lane out of the memory word and extend it to 32 bits.
  function automatic logic [31:0] f_extract(input logic [31:0] word, input logic [1:0] size,
                                            input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   res = {{24{sgn & b[7]}}, b};
      2'b01:   res = {{16{sgn & h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] size, input logic [1:0] off);
    logic [31:0] res;
    res = old;
    if (size == 2'b00) begin
      case (off)
        2'd0:    res[7:0]   = wd[7:0];
        2'd1:    res[15:8]  = wd[7:0];
        2'd2:    res[23:16] = wd[7:0];
        default: res[31:24] = wd[7:0];
      endcase
    end else if (size == 2'b01) begin
      if (off[1]) res[31:16] = wd[15:0];
      else        res[15:0]  = wd[15:0];
    end else begin
      res = wd;
    end
    return res;
  endfunction

`ifdef LSU_RANGE_CHECK_EN
  logic w_range_err;
  assign w_range_err = |req_addr[31:ADDR_W+2];
`else
  logic w_range_err;
  logic w_unused_addr;
  assign w_range_err   = 1'b0;
  assign w_unused_addr = ^req_addr[31:ADDR_W+2];
`endif

  assign w_req_err = (req_size == 2'b11) ||
                     (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
                     w_range_err;

  assign req_ready    = !reset && (r_state == S_IDLE);
  assign w_accept     = req_valid && req_ready;
  assign w_word_store = r_write && (r_size == 2'b10);

  // Enables are gated by reset so an abort never commits a write.
  assign mem_read  = !reset && (r_state == S_ACCESS) && !w_word_store;
  assign mem_write = !reset && (((r_state == S_ACCESS) && w_word_store) || (r_state == S_WRITE));

  assign mem_addr       = r_mem_addr;
  assign mem_write_data = r_mem_wdata;
  assign resp_valid     = r_resp_valid;
  assign resp_err       = r_resp_err;
  assign resp_rdata     = r_resp_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_write      <= 1'b0;
      r_size       <= 2'b00;
      r_signed     <= 1'b0;
      r_off        <= 2'b00;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_write      <= req_write;
            r_size       <= req_size;
            r_signed     <= req_signed;
            r_off        <= req_addr[1:0];
            r_wdata      <= req_wdata;
            r_resp_rdata <= '0;
            if (w_req_err) begin
              r_state      <= S_ERR;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end else begin
              r_state    <= S_ACCESS;
              r_mem_addr <= req_addr[ADDR_W+1:2];
              if (req_write && req_size == 2'b10) r_mem_wdata <= req_wdata;
            end
          end
        end
        S_ACCESS: begin
          if (w_word_store) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
          end else if (r_write) begin
            r_mem_wdata <= f_merge(mem_read_data, r_wdata, r_size, r_off);
            r_state     <= S_WRITE;
          end else begin
            r_resp_rdata <= f_extract(mem_read_data, r_size, r_off, r_signed);
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
          end
        end
        S_WRITE: begin
          r_state      <= S_RESP;
          r_resp_valid <= 1'b1;
        end
        S_RESP, S_ERR: begin
          r_state      <= S_IDLE;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
